mispredict_recovery_ctrl: RTL and testbench

Sequences pipeline recovery after the resolved-branch selector reports a taken misprediction or a full flush. Holds the flush window open for a fixed number of cycles, then hands the redirect target to fetch with a ready/valid handshake, then runs the rename-map restore and waits for it to finish. Older branches that arrive mid-recovery pre-empt the current recovery; younger ones are dropped. The block drives the mispredict-flush qualifier that is fed back to the branch selector.

---
 rtl/mispredict_recovery_ctrl_if.sv | 39 +++
 rtl/mispredict_recovery_ctrl.sv | 127 ++++++++++++
 tb/tb_mispredict_recovery_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mispredict_recovery_ctrl_if.sv
// Recovery-controller signal bundle.
// Groups the branch-selector input, the fetch redirect handshake, the rename
// restore handshake and the perf-counter pulses into one interface.
//   master : the recovery controller (drives OUT_*, samples IN_*)
//   slave  : the surrounding pipeline (drives IN_*, samples OUT_*)
interface mispredict_recovery_ctrl_if #(
  parameter int SQN_W = 7,
  parameter int PC_W  = 32
);
  logic             IN_branchValid;
  logic             IN_branchFlush;
  logic [SQN_W-1:0] IN_branchSqN;
  logic [PC_W-1:0]  IN_branchDst;
  logic             OUT_mispredFlush;
  logic             OUT_stall;
  logic [SQN_W-1:0] OUT_recSqN;
  logic             OUT_redirValid;
  logic [PC_W-1:0]  OUT_redirPC;
  logic             IN_fetchReady;
  logic             OUT_restoreStart;
  logic             OUT_restoreFull;
  logic             IN_restoreDone;
  logic             OUT_PERFC_mispr;
  logic             OUT_PERFC_squash;

  modport master (
    input  IN_branchValid, IN_branchFlush, IN_branchSqN, IN_branchDst,
    input  IN_fetchReady, IN_restoreDone,
    output OUT_mispredFlush, OUT_stall, OUT_recSqN, OUT_redirValid, OUT_redirPC,
    output OUT_restoreStart, OUT_restoreFull, OUT_PERFC_mispr, OUT_PERFC_squash
  );

  modport slave (
    output IN_branchValid, IN_branchFlush, IN_branchSqN, IN_branchDst,
    output IN_fetchReady, IN_restoreDone,
    input  OUT_mispredFlush, OUT_stall, OUT_recSqN, OUT_redirValid, OUT_redirPC,
    input  OUT_restoreStart, OUT_restoreFull, OUT_PERFC_mispr, OUT_PERFC_squash
  );
endinterface

// File: rtl/mispredict_recovery_ctrl.sv
// Mispredict / flush recovery sequencer.
// Accepts a taken mispredict or full flush from the branch selector, holds the
// flush window for FLUSH_CYCLES cycles, hands the redirect target to fetch with
// a ready/valid handshake, then runs the rename-map restore until it reports
// done. Older branches (or any full flush) pre-empt a running recovery; younger
// ones are dropped and counted.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-low
//   bus  : mispredict_recovery_ctrl_if.master (branch in, redirect, restore, perf)
// All outputs are driven from flops.
module mispredict_recovery_ctrl #(
  parameter int SQN_W        = 7,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  mispredict_recovery_ctrl_if.master    bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT, RESTORE} state_t;

  state_t           state, state_d;
  logic [3:0]       cnt, cnt_d;
  logic [SQN_W-1:0] rec_sqn, rec_sqn_d;
  logic [PC_W-1:0]  rec_pc, rec_pc_d;
  logic             rec_full, rec_full_d;
  logic             accept, squash;

  logic mispred_flush_d, stall_d, redir_valid_d;
  logic restore_start_d, restore_full_d, perfc_mispr_d, perfc_squash_d;

  // Modular age compare: a is strictly older than b when (a - b) is negative
  // as an SQN_W-bit signed value, so the comparison survives sqN wrap-around.
  function automatic logic is_older(input logic [SQN_W-1:0] a,
                                    input logic [SQN_W-1:0] b);
    logic signed [SQN_W-1:0] diff;
    diff = signed'(a - b);
    return diff < 0;
  endfunction

  // State and capture registers, plus the registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      rec_sqn              <= '0;
      rec_pc               <= '0;
      rec_full             <= 1'b0;
      bus.OUT_mispredFlush <= 1'b0;
      bus.OUT_stall        <= 1'b0;
      bus.OUT_redirValid   <= 1'b0;
      bus.OUT_restoreStart <= 1'b0;
      bus.OUT_restoreFull  <= 1'b0;
      bus.OUT_PERFC_mispr  <= 1'b0;
      bus.OUT_PERFC_squash <= 1'b0;
    end else begin
      state                <= state_d;
      cnt                  <= cnt_d;
      rec_sqn              <= rec_sqn_d;
      rec_pc               <= rec_pc_d;
      rec_full             <= rec_full_d;
      bus.OUT_mispredFlush <= mispred_flush_d;
      bus.OUT_stall        <= stall_d;
      bus.OUT_redirValid   <= redir_valid_d;
      bus.OUT_restoreStart <= restore_start_d;
      bus.OUT_restoreFull  <= restore_full_d;
      bus.OUT_PERFC_mispr  <= perfc_mispr_d;
      bus.OUT_PERFC_squash <= perfc_squash_d;
    end
  end

  // Capture flops feed these directly; redirPC is stable for the whole
  // REDIRECT phase because recPC only changes on an accept.
  assign bus.OUT_recSqN  = rec_sqn;
  assign bus.OUT_redirPC = rec_pc;

  // Next-state: an accepted branch overrides every other transition
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rec_sqn_d  = rec_sqn;
    rec_pc_d   = rec_pc;
    rec_full_d = rec_full;
    accept     = 1'b0;
    squash     = 1'b0;

    if (bus.IN_branchValid) begin
      if (state == IDLE || bus.IN_branchFlush ||
          (!rec_full && is_older(bus.IN_branchSqN, rec_sqn)))
        accept = 1'b1;
      else
        squash = 1'b1;
    end

    if (accept) begin
      rec_sqn_d  = bus.IN_branchSqN;
      rec_pc_d   = bus.IN_branchDst;
      rec_full_d = bus.IN_branchFlush;
      cnt_d      = 4'(FLUSH_CYCLES - 1);
      state_d    = FLUSH;
    end else begin
      case (state)
        FLUSH: begin
          if (cnt == 4'd0) state_d = REDIRECT;
          else             cnt_d   = cnt - 4'd1;
        end
        REDIRECT: if (bus.IN_fetchReady)  state_d = RESTORE;
        RESTORE:  if (bus.IN_restoreDone) state_d = IDLE;
        default:  ;
      endcase
    end
  end

  // Output decode from the next state, registered above
  always_comb begin
    mispred_flush_d = (state_d == FLUSH);
    stall_d         = (state_d != IDLE);
    redir_valid_d   = (state_d == REDIRECT);
    restore_start_d = (state == REDIRECT) && (state_d == RESTORE);
    restore_full_d  = (state_d == RESTORE) && rec_full_d;
    perfc_mispr_d   = accept && !bus.IN_branchFlush;
    perfc_squash_d  = squash;
  end

endmodule

// File: tb/tb_mispredict_recovery_ctrl.sv
module tb_mispredict_recovery_ctrl;

  localparam int SQN_W = 7;
  localparam int PC_W  = 32;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mispredict_recovery_ctrl_if #(.SQN_W(SQN_W), .PC_W(PC_W)) bus ();

  mispredict_recovery_ctrl #(.SQN_W(SQN_W), .PC_W(PC_W), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic branch(input logic v, input logic f, input logic [SQN_W-1:0] s,
                        input logic [PC_W-1:0] d);
    bus.IN_branchValid = v;
    bus.IN_branchFlush = f;
    bus.IN_branchSqN   = s;
    bus.IN_branchDst   = d;
  endtask

  initial begin
    rst = 1'b0;
    branch(1'b0, 1'b0, '0, '0);
    bus.IN_fetchReady  = 1'b0;
    bus.IN_restoreDone = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_mflush",  bus.OUT_mispredFlush, 0);
    chk("rst_stall",   bus.OUT_stall, 0);
    chk("rst_recsqn",  bus.OUT_recSqN, 0);
    chk("rst_rvalid",  bus.OUT_redirValid, 0);
    chk("rst_rpc",     bus.OUT_redirPC, 0);
    chk("rst_rstart",  bus.OUT_restoreStart, 0);
    chk("rst_rfull",   bus.OUT_restoreFull, 0);
    chk("rst_pmispr",  bus.OUT_PERFC_mispr, 0);
    chk("rst_psquash", bus.OUT_PERFC_squash, 0);
    rst = 1'b1;
    tick();

    // Basic recovery: accept in cycle 0, fetchReady held high
    branch(1'b1, 1'b0, 7'h10, 32'h8000);
    bus.IN_fetchReady = 1'b1;
    tick();                                     // cycle 1
    branch(1'b0, 1'b0, '0, '0);
    chk("t1_c1_mflush", bus.OUT_mispredFlush, 1);
    chk("t1_c1_stall",  bus.OUT_stall, 1);
    chk("t1_c1_pmispr", bus.OUT_PERFC_mispr, 1);
    chk("t1_c1_recsqn", bus.OUT_recSqN, 7'h10);
    chk("t1_c1_rvalid", bus.OUT_redirValid, 0);
    tick();                                     // cycle 2
    chk("t1_c2_mflush", bus.OUT_mispredFlush, 1);
    chk("t1_c2_pmispr", bus.OUT_PERFC_mispr, 0);
    chk("t1_c2_rvalid", bus.OUT_redirValid, 0);
    tick();                                     // cycle 3
    chk("t1_c3_mflush", bus.OUT_mispredFlush, 0);
    chk("t1_c3_rvalid", bus.OUT_redirValid, 1);
    chk("t1_c3_rpc",    bus.OUT_redirPC, 32'h8000);
    chk("t1_c3_rstart", bus.OUT_restoreStart, 0);
    tick();                                     // cycle 4
    bus.IN_fetchReady = 1'b0;
    chk("t1_c4_rstart", bus.OUT_restoreStart, 1);
    chk("t1_c4_rfull",  bus.OUT_restoreFull, 0);
    chk("t1_c4_rvalid", bus.OUT_redirValid, 0);
    chk("t1_c4_stall",  bus.OUT_stall, 1);
    tick();                                     // cycle 5
    chk("t1_c5_rstart", bus.OUT_restoreStart, 0);
    chk("t1_c5_stall",  bus.OUT_stall, 1);
    bus.IN_restoreDone = 1'b1;
    tick();                                     // cycle 6
    bus.IN_restoreDone = 1'b0;
    chk("t1_c6_stall",  bus.OUT_stall, 0);

    // Pre-emption by an older branch, then a younger one dropped
    branch(1'b1, 1'b0, 7'h10, 32'h8000);
    tick();
    branch(1'b1, 1'b0, 7'h08, 32'h4000);
    tick();
    chk("t2_pre_recsqn", bus.OUT_recSqN, 7'h08);
    chk("t2_pre_mflush", bus.OUT_mispredFlush, 1);
    chk("t2_pre_pmispr", bus.OUT_PERFC_mispr, 1);
    branch(1'b1, 1'b0, 7'h20, 32'h1111);
    tick();
    branch(1'b0, 1'b0, '0, '0);
    chk("t2_drop_psquash", bus.OUT_PERFC_squash, 1);
    chk("t2_drop_pmispr",  bus.OUT_PERFC_mispr, 0);
    chk("t2_drop_recsqn",  bus.OUT_recSqN, 7'h08);
    chk("t2_restart_mflush", bus.OUT_mispredFlush, 1);
    tick();
    chk("t2_rvalid", bus.OUT_redirValid, 1);
    chk("t2_rpc",    bus.OUT_redirPC, 32'h4000);
    chk("t2_psquash_clr", bus.OUT_PERFC_squash, 0);
    bus.IN_fetchReady = 1'b1;
    tick();
    bus.IN_fetchReady  = 1'b0;
    chk("t2_rstart", bus.OUT_restoreStart, 1);
    bus.IN_restoreDone = 1'b1;                 // done together with the start pulse
    tick();
    bus.IN_restoreDone = 1'b0;
    chk("t2_idle_stall", bus.OUT_stall, 0);

    // Wrap-around age compare
    branch(1'b1, 1'b0, 7'h7E, 32'h7E00);
    tick();
    branch(1'b1, 1'b0, 7'h01, 32'h0100);
    tick();
    chk("t3_young_psquash", bus.OUT_PERFC_squash, 1);
    chk("t3_young_recsqn",  bus.OUT_recSqN, 7'h7E);
    branch(1'b1, 1'b0, 7'h7C, 32'h7C00);
    tick();
    branch(1'b0, 1'b0, '0, '0);
    chk("t3_old_recsqn", bus.OUT_recSqN, 7'h7C);
    chk("t3_old_pmispr", bus.OUT_PERFC_mispr, 1);
    chk("t3_old_mflush", bus.OUT_mispredFlush, 1);
    tick();
    tick();

    // Redirect held off by fetch, then pre-empted by a full flush
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_rvalid", bus.OUT_redirValid, 1);
      chk("t4_hold_rpc",    bus.OUT_redirPC, 32'h7C00);
      tick();
    end
    chk("t4_hold_rvalid_end", bus.OUT_redirValid, 1);
    branch(1'b1, 1'b1, 7'h50, 32'hA000);
    tick();
    chk("t4_flush_mflush", bus.OUT_mispredFlush, 1);
    chk("t4_flush_rvalid", bus.OUT_redirValid, 0);
    chk("t4_flush_pmispr", bus.OUT_PERFC_mispr, 0);
    chk("t4_flush_recsqn", bus.OUT_recSqN, 7'h50);
    branch(1'b1, 1'b0, 7'h40, 32'h4040);       // older, but recovery is a full flush
    tick();
    branch(1'b0, 1'b0, '0, '0);
    chk("t4_old_psquash", bus.OUT_PERFC_squash, 1);
    chk("t4_old_recsqn",  bus.OUT_recSqN, 7'h50);
    tick();
    chk("t4_rvalid", bus.OUT_redirValid, 1);
    chk("t4_rpc",    bus.OUT_redirPC, 32'hA000);
    bus.IN_fetchReady = 1'b1;
    tick();
    bus.IN_fetchReady = 1'b0;
    chk("t4_rstart", bus.OUT_restoreStart, 1);
    chk("t4_rfull",  bus.OUT_restoreFull, 1);

    // Accept in the same cycle as restoreDone
    bus.IN_restoreDone = 1'b1;
    branch(1'b1, 1'b1, 7'h30, 32'hB000);
    tick();
    bus.IN_restoreDone = 1'b0;
    branch(1'b0, 1'b0, '0, '0);
    chk("t5_mflush", bus.OUT_mispredFlush, 1);
    chk("t5_stall",  bus.OUT_stall, 1);
    chk("t5_recsqn", bus.OUT_recSqN, 7'h30);
    chk("t5_rfull",  bus.OUT_restoreFull, 0);
    tick();
    tick();
    chk("t5_rvalid", bus.OUT_redirValid, 1);

    // Reset during REDIRECT with a branch presented in the reset cycle
    rst = 1'b0;
    branch(1'b1, 1'b0, 7'h05, 32'h0500);
    tick();
    chk("t6_rst_rvalid", bus.OUT_redirValid, 0);
    chk("t6_rst_rpc",    bus.OUT_redirPC, 0);
    chk("t6_rst_stall",  bus.OUT_stall, 0);
    chk("t6_rst_mflush", bus.OUT_mispredFlush, 0);
    chk("t6_rst_recsqn", bus.OUT_recSqN, 0);
    chk("t6_rst_pmispr", bus.OUT_PERFC_mispr, 0);
    rst = 1'b1;
    branch(1'b0, 1'b0, '0, '0);
    tick();
    chk("t6_after_stall",  bus.OUT_stall, 0);
    chk("t6_after_mflush", bus.OUT_mispredFlush, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
